instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the opcode decoder: packs instruction kind + fields into 32-bit MIPS words
//  (R-type, lw, sw, beq) for the instruction-memory loader.
//  Buffered valid/ready stream: field-level source on the input, imem writer on the output.
//  Tags each emitted word with its sequential byte address.
// PARAMETERS
//  DEPTH      4    output FIFO entries; power of 2, >=2
//  ADDR_W     10   width of out_addr (byte address)
//  BASE_ADDR  0    address of first emitted word; must be a multiple of 4
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       encoder can accept a beat
//  in_kind    in   3       0=R 1=lw 2=sw 3=beq 4..7=unsupported
//  in_rs      in   5       rs field
//  in_rt      in   5       rt field
//  in_rd      in   5       rd field (R only)
//  in_shamt   in   5       shamt field (R only)
//  in_funct   in   6       funct field (R only)
//  in_imm     in   16      immediate/offset (lw/sw/beq)
//  out_valid  out  1       out_instr/out_addr valid
//  out_ready  in   1       sink accepts word
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  byte address of out_instr
//  level      out  $clog2(DEPTH)+1  FIFO occupancy
//  err_unsup  out  1       one-cycle pulse: unsupported kind consumed
//  err_count  out  8       saturating count of unsupported beats
// BEHAVIOUR
//  Reset (rst high at edge): FIFO empty, level=0, out_valid=0, out_instr=0,
//   out_addr=BASE_ADDR, err_unsup=0, err_count=0. in_ready=0 while rst high.
//  Accept: in_valid & in_ready at an edge. in_ready = (level != DEPTH) & ~rst;
//   it is a function of registered state only; no combinational in->out path.
//  Encoding, registered into the FIFO on accept:
//   R:   {6'd0,  rs, rt, rd, shamt, funct}
//   lw:  {6'd35, rs, rt, imm}
//   sw:  {6'd43, rs, rt, imm}
//   beq: {6'd4,  rs, rt, imm}
//   Fields unused by a kind are ignored.
//  Unsupported kind (4..7): still accepted (in_ready obeyed) but not written to FIFO.
//   err_unsup=1 the next cycle; err_count+1, saturating at 255; level unchanged.
//  Latency: word accepted at edge N appears on out_* after edge N, if FIFO was empty.
//   Otherwise it follows in order behind older words. No fall-through.
//  Output: out_valid = (level != 0); out_instr = head entry.
//   Transfer when out_valid & out_ready at an edge.
//   Each transfer advances out_addr by 4, wrapping mod 2^ADDR_W.
//   out_addr always names the current head word.
//  out_instr/out_addr stable while out_valid & ~out_ready (no change until transfer).
//  out_instr holds last value when empty (don't care for the sink).
//  Simultaneous push+pop: level unchanged; legal at any non-full level.
//   When full, in_ready=0, so no push occurs.
//  Pointers: read/write pointers wrap mod DEPTH.
//   level = write count - read count, range 0..DEPTH.
//  Reset mid-stream: all buffered words discarded; address restarts at BASE_ADDR.
//  Beat with in_valid=1 at a reset edge is dropped.
// TESTING
//  1 rst 2 cycles; then R rs=1 rt=2 rd=3 shamt=0 funct=0x20, out_ready=1
//   -> next cycle out_valid=1, out_instr=0x00221820, out_addr=0.
//  2 lw rs=29 rt=8 imm=0x0004, then sw same fields, then beq rs=8 rt=9 imm=0xFFFF
//   -> 0x8FA80004 @0, 0xAFA80004 @4, 0x1109FFFF @8.
//  3 out_ready=0, push 5 R beats (DEPTH=4) -> in_ready=0 after 4th, level=4,
//   out_instr stable; release -> 4 words in order, 5th then accepted.
//  4 in_kind=5 with valid -> accepted, err_unsup pulse 1 cycle, err_count=1, no out_valid;
//   256 such beats -> err_count=255.
//  5 ADDR_W=4, stream 5 words -> out_addr 0,4,8,12,0.
//  6 rst asserted with level=3 -> next cycle level=0, out_valid=0, out_addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Stream interface for the MIPS instruction encoder.
//   Input side : field-level beats (in_valid/in_ready + instruction fields).
//   Output side: encoded words tagged with byte address (out_valid/out_ready).
// Handshake: a beat or word moves on a rising edge where valid and ready are
// both high. Valid must not depend on ready. Payload is only meaningful while
// valid is high.
// Modports:
//   slave  - the encoder: consumes field beats, produces words.
//   master - the environment: produces field beats, consumes words.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
        output in_ready,
        output out_valid, out_instr, out_addr,
        input  out_ready
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
        input  in_ready,
        input  out_valid, out_instr, out_addr,
        output out_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction kind + fields into 32-bit MIPS words
// (R-type, lw, sw, beq) and buffers them in a small FIFO, tagging each
// emitted word with its sequential byte address.
// Ports:
//   clk, rst   - single clock, synchronous active-high reset
//   bus        - instr_encoder_if.slave (field beats in, addressed words out)
//   level      - FIFO occupancy, 0..DEPTH
//   err_unsup  - one-cycle pulse after an unsupported kind is consumed
//   err_count  - saturating count of unsupported beats
// No combinational path from inputs to outputs: in_ready, out_valid,
// out_instr and out_addr all come from registered state (and rst).
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_encoder_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_unsup,
    output logic [7:0]             err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       head_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word;
    logic              supported;
    logic              accept;
    logic              push;
    logic              pop;

    assign bus.in_ready  = (level != LVL_W'(DEPTH)) & ~rst;
    assign bus.out_valid = (level != '0);
    assign bus.out_instr = head_q;
    assign bus.out_addr  = addr_q;

    assign supported = ~bus.in_kind[2];
    assign accept    = bus.in_valid & bus.in_ready;
    assign push      = accept & supported;
    assign pop       = bus.out_valid & bus.out_ready;

    always_comb begin
        word = '0;
        case (bus.in_kind)
            3'd0:    word = {6'd0,  bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            3'd1:    word = {6'd35, bus.in_rs, bus.in_rt, bus.in_imm};
            3'd2:    word = {6'd43, bus.in_rs, bus.in_rt, bus.in_imm};
            3'd3:    word = {6'd4,  bus.in_rs, bus.in_rt, bus.in_imm};
            default: word = '0;
        endcase
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            head_q    <= '0;
            addr_q    <= ADDR_W'(BASE_ADDR);
            err_unsup <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                addr_q <= addr_q + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // The head register is the visible output word. It is loaded with
            // the incoming word when that word becomes the head (FIFO empty, or
            // the only stored word leaving this cycle), with the next stored
            // word on a pop that leaves others behind, and otherwise holds --
            // so it keeps its last value when the FIFO drains.
            if (push && (level == '0 || (pop && level == LVL_W'(1)))) begin
                head_q <= word;
            end else if (pop && level > LVL_W'(1)) begin
                head_q <= mem[rd_ptr + PTR_W'(1)];
            end
            err_unsup <= accept & ~supported;
            if (accept && !supported && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A queue-based reference model tracks
// expected FIFO contents, head address, and error counters; every cycle the
// DUT outputs are compared against it. A second instance with ADDR_W=4 shares
// the same input stream and checks address wrap at 16.
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int BASE  = 0;

    logic       clk;
    logic       rst;
    logic [2:0] level1;
    logic       err_unsup1;
    logic [7:0] err_count1;
    logic [2:0] level2;
    logic       err_unsup2;
    logic [7:0] err_count2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          exp_addr;
    int          exp_err_cnt;
    bit          exp_err_pulse;
    logic [31:0] last_instr;

    instr_encoder_if #(.ADDR_W(10)) bus1 ();
    instr_encoder_if #(.ADDR_W(4))  bus2 ();

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_kind   = bus1.in_kind;
    assign bus2.in_rs     = bus1.in_rs;
    assign bus2.in_rt     = bus1.in_rt;
    assign bus2.in_rd     = bus1.in_rd;
    assign bus2.in_shamt  = bus1.in_shamt;
    assign bus2.in_funct  = bus1.in_funct;
    assign bus2.in_imm    = bus1.in_imm;
    assign bus2.out_ready = bus1.out_ready;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus1),
        .level(level1), .err_unsup(err_unsup1), .err_count(err_count1)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(BASE)) dut_w4 (
        .clk(clk), .rst(rst), .bus(bus2),
        .level(level2), .err_unsup(err_unsup2), .err_count(err_count2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding from field positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm);
        longint w;
        longint op;
        case (kind)
            1:       op = 35;
            2:       op = 43;
            3:       op = 4;
            default: op = 0;
        endcase
        w = op * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16);
        if (kind == 0) w = w + rd * (64'd1 << 11) + sh * (64'd1 << 6) + fn;
        else           w = w + imm;
        return w[31:0];
    endfunction

    task automatic check_state();
        check("in_ready",   {31'd0, bus1.in_ready},  (rst || exp_q.size() == DEPTH) ? 32'd0 : 32'd1);
        check("level",      {29'd0, level1},         32'(exp_q.size()));
        check("out_valid",  {31'd0, bus1.out_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        check("out_instr",  bus1.out_instr,          last_instr);
        check("out_addr",   {22'd0, bus1.out_addr},  32'(exp_addr));
        check("out_addr_w4",{28'd0, bus2.out_addr},  32'(exp_addr % 16));
        check("err_unsup",  {31'd0, err_unsup1},     {31'd0, exp_err_pulse});
        check("err_count",  {24'd0, err_count1},     32'(exp_err_cnt));
    endtask

    // driver: one clock cycle with the given inputs, model advanced at the edge
    task automatic cycle(input bit r, input bit v, input int k, input int rs, input int rt,
                         input int rd, input int sh, input int fn, input int imm,
                         input bit ordy);
        bit acc;
        bit pop;
        rst            = r;
        bus1.in_valid  = v;
        bus1.in_kind   = 3'(k);
        bus1.in_rs     = 5'(rs);
        bus1.in_rt     = 5'(rt);
        bus1.in_rd     = 5'(rd);
        bus1.in_shamt  = 5'(sh);
        bus1.in_funct  = 6'(fn);
        bus1.in_imm    = 16'(imm);
        bus1.out_ready = ordy;
        @(negedge clk);
        check_state();
        acc = v && !r && exp_q.size() != DEPTH;
        pop = !r && exp_q.size() != 0 && ordy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            exp_addr      = BASE;
            exp_err_cnt   = 0;
            exp_err_pulse = 0;
            last_instr    = '0;
        end else begin
            exp_err_pulse = acc && k >= 4;
            if (exp_err_pulse && exp_err_cnt < 255) exp_err_cnt++;
            if (pop) begin
                void'(exp_q.pop_front());
                exp_addr = (exp_addr + 4) % 1024;
            end
            if (acc && k < 4) exp_q.push_back(ref_word(k, rs, rt, rd, sh, fn, imm));
            if (exp_q.size() != 0) last_instr = exp_q[0];
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int addr_seq[5];

    initial begin
        rst = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_kind   = '0;
        bus1.in_rs     = '0;
        bus1.in_rt     = '0;
        bus1.in_rd     = '0;
        bus1.in_shamt  = '0;
        bus1.in_funct  = '0;
        bus1.in_imm    = '0;
        bus1.out_ready = 1'b0;
        exp_addr = BASE; exp_err_cnt = 0; exp_err_pulse = 0; last_instr = '0;
        @(posedge clk);
        #1;

        // reset then a single R-type word
        do_reset(2);
        check("rst_level", {29'd0, level1}, 32'd0);
        cycle(0, 1, 0, 1, 2, 3, 0, 32'h20, 0, 1);
        check("t1_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("t1_instr", bus1.out_instr, 32'h0022_1820);
        check("t1_addr",  {22'd0, bus1.out_addr}, 32'd0);
        idle(1);

        // lw / sw / beq, drained one at a time
        do_reset(1);
        cycle(0, 1, 1, 29, 8, 0, 0, 0, 16'h0004, 0);
        cycle(0, 1, 2, 29, 8, 0, 0, 0, 16'h0004, 0);
        cycle(0, 1, 3, 8, 9, 0, 0, 0, 16'hFFFF, 0);
        check("t2_lw",   bus1.out_instr, 32'h8FA8_0004);
        check("t2_lw_a", {22'd0, bus1.out_addr}, 32'd0);
        idle(1);
        check("t2_sw",   bus1.out_instr, 32'hAFA8_0004);
        check("t2_sw_a", {22'd0, bus1.out_addr}, 32'd4);
        idle(1);
        check("t2_beq",   bus1.out_instr, 32'h1109_FFFF);
        check("t2_beq_a", {22'd0, bus1.out_addr}, 32'd8);
        idle(1);

        // fill to full with the sink stalled, then release
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, i, i + 1, i + 2, i, 32 + i, 0, 0);
        check("t3_full_ready", {31'd0, bus1.in_ready}, 32'd0);
        check("t3_full_level", {29'd0, level1}, 32'd4);
        cycle(0, 1, 0, 9, 9, 9, 9, 9, 0, 0);
        cycle(0, 1, 0, 9, 9, 9, 9, 9, 0, 1);
        cycle(0, 1, 0, 9, 9, 9, 9, 9, 0, 1);
        for (int i = 0; i < 6; i++) idle(1);

        // reset with three words buffered and a beat on the input
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, i, i, 0, 0, 0, i * 100, 0);
        check("t6_level3", {29'd0, level1}, 32'd3);
        cycle(1, 1, 0, 1, 1, 1, 1, 1, 0, 1);
        check("t6_level0", {29'd0, level1}, 32'd0);
        check("t6_valid0", {31'd0, bus1.out_valid}, 32'd0);
        check("t6_addr",   {22'd0, bus1.out_addr}, 32'(BASE));

        // narrow address wrap: 0,4,8,12,0
        addr_seq = '{0, 4, 8, 12, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, i, 0, 0, 0, 0, 0, 0);
            check("t5_addr_w4", {28'd0, bus2.out_addr}, 32'(addr_seq[i]));
            idle(1);
        end

        // unsupported kind: pulse, count, saturation
        cycle(0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        check("t4_pulse", {31'd0, err_unsup1}, 32'd1);
        check("t4_count", {24'd0, err_count1}, 32'd1);
        check("t4_noout", {31'd0, bus1.out_valid}, 32'd0);
        idle(1);
        check("t4_pulse_end", {31'd0, err_unsup1}, 32'd0);
        for (int i = 0; i < 256; i++) cycle(0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        check("t4_sat", {24'd0, err_count1}, 32'd255);

        // randomized traffic
        do_reset(1);
        for (int i = 0; i < 2000; i++) begin
            int k;
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            cycle($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, k,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
                  $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
